// File: rtl/burst_arb_pkg.sv
// Shared types and the round-robin search function for the burst grant arbiter.
package burst_arb_pkg;

    // Widest requester vector the search function handles.
    localparam int unsigned MaxReq = 32;
    localparam int unsigned MaxIdW = 5;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease
    } state_e;

    typedef struct packed {
        logic        valid;
        int unsigned idx;
    } pick_t;

    // First set bit of req[n-1:0] at or above ptr, wrapping past n-1 to 0.
    // Walking ptr, ptr+1, ... mod n is the rotate / find-first / unrotate in one pass.
    function automatic pick_t rr_pick(input logic [MaxReq-1:0] req,
                                      input int unsigned       ptr,
                                      input int unsigned       n);
        pick_t       res;
        int unsigned j;
        res = '0;
        for (int unsigned i = 0; i < MaxReq; i++) begin
            if (i < n && !res.valid) begin
                j = ptr + i;
                if (j >= n) begin
                    j = j - n;
                end
                if (req[j[MaxIdW-1:0]]) begin
                    res.valid = 1'b1;
                    res.idx   = j;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: lowest set request at or after ptr, with wrap.
module rr_priority_picker
    import burst_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 4,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    logic [MaxReq-1:0] req_ext;
    pick_t             pick;
    logic              unused_pick;

    // Zero-extend the request vector and run the wrap-around search.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        pick                 = rr_pick(req_ext, 32'(ptr), NUM_REQ);
    end

    assign valid       = pick.valid;
    assign idx         = pick.idx[ID_W-1:0];
    // Upper index bits are always zero for a valid pick.
    assign unused_pick = ^pick;

endmodule

// File: rtl/burst_grant_arbiter.sv
// Round-robin arbiter handing out bursts of consecutive grant cycles to one requester.
module burst_grant_arbiter
    import burst_arb_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 4,
    parameter int unsigned  CNT_W   = 3,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [CNT_W-1:0]   num_grants,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               last,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] owner_oh;
    logic               owner_req;
    logic [ID_W-1:0]    next_ptr;
    logic [CNT_W-1:0]   eff_len_m1;
    logic [NUM_REQ-1:0] pick_req;
    logic [ID_W-1:0]    pick_ptr;
    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;

    assign owner_oh   = NUM_REQ'(1) << owner_q;
    assign owner_req  = req[owner_q];
    assign next_ptr   = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    // A zero burst length is treated as a single grant cycle.
    assign eff_len_m1 = (num_grants == '0) ? '0 : num_grants - 1'b1;

    // In RELEASE the outgoing owner is excluded and the search starts just past it.
    always_comb begin
        pick_req = req;
        pick_ptr = rr_ptr_q;
        if (state_q == StRelease) begin
            pick_req = req & ~owner_oh;
            pick_ptr = next_ptr;
        end
    end

    rr_priority_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .req  (pick_req),
        .ptr  (pick_ptr),
        .valid(pick_valid),
        .idx  (pick_idx)
    );

    // Next-state logic for the burst FSM, counter, owner and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StGrant;
                    owner_d = pick_idx;
                    count_d = eff_len_m1;
                end
            end
            StGrant: begin
                if (!owner_req) begin
                    // Owner gave up mid-burst: drop the grant without a last.
                    state_d  = StIdle;
                    rr_ptr_d = next_ptr;
                end else if (count_q == '0) begin
                    state_d = StRelease;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            StRelease: begin
                // A held owner request keeps us here; nobody else is served.
                if (!owner_req) begin
                    rr_ptr_d = next_ptr;
                    if (pick_valid) begin
                        state_d = StGrant;
                        owner_d = pick_idx;
                        count_d = eff_len_m1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Outputs are decoded from registered state only; last also qualifies on the owner's req.
    always_comb begin
        gnt    = (state_q == StGrant) ? owner_oh : '0;
        gnt_id = owner_q;
        last   = (state_q == StGrant) && (count_q == '0) && owner_req;
        busy   = (state_q != StIdle);
    end

endmodule

// File: tb/tb_burst_grant_arbiter.sv
// Self-checking bench for burst_grant_arbiter: vector table plus hand-written sequences.
module tb_burst_grant_arbiter;

    localparam int unsigned NumReq = 4;
    localparam int unsigned CntW   = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [2:0] num_grants;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       last;
    logic       busy;

    burst_grant_arbiter #(
        .NUM_REQ(NumReq),
        .CNT_W  (CntW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .num_grants(num_grants),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .last      (last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // One row = inputs held for one cycle and the outputs expected during that cycle.
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [2:0] ng;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       last;
        logic       busy;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       last;
        logic       busy;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    task automatic add(input logic rst, input logic [3:0] r, input logic [2:0] ng,
                       input logic [3:0] g, input logic [1:0] id, input logic l,
                       input logic b, input string nm);
        vec_t v;
        v.rst  = rst;
        v.req  = r;
        v.ng   = ng;
        v.gnt  = g;
        v.id   = id;
        v.last = l;
        v.busy = b;
        v.name = nm;
        vecs.push_back(v);
    endtask

    // Called just after a posedge; drives inputs, checks at negedge, returns after next posedge.
    task automatic cyc(input logic rst, input logic [3:0] r, input logic [2:0] ng,
                       input logic [3:0] g, input logic [1:0] id, input logic l,
                       input logic b, input string nm);
        exp_t e;
        exp_t got;
        reset      = rst;
        req        = r;
        num_grants = ng;
        e.gnt  = g;
        e.id   = id;
        e.last = l;
        e.busy = b;
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        got = sb.pop_front();
        n_tests++;
        if ({gnt, gnt_id, last, busy} !== {got.gnt, got.id, got.last, got.busy}) begin
            n_fail++;
            $display("FAIL %s @%0t: got gnt=%b id=%0d last=%b busy=%b, want gnt=%b id=%0d last=%b busy=%b",
                     got.name, $time, gnt, gnt_id, last, busy, got.gnt, got.id, got.last,
                     got.busy);
        end
        @(posedge clk);
        #1;
    endtask

    // Structural invariants checked every cycle once out of initial reset.
    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (!$onehot0(gnt) || (last && gnt == 4'b0000)) begin
                n_fail++;
                $display("FAIL invariant @%0t: got gnt=%b last=%b, want one-hot-or-zero gnt and no last without gnt",
                         $time, gnt, last);
            end
        end
    end

    initial begin
        logic [1:0] o;
        logic [3:0] oh;
        logic [3:0] rel_req;

        // Single requester, burst of 2.
        add(1'b1, 4'b0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0, "reset_state");
        add(1'b0, 4'b0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0, "idle_no_req");
        add(1'b0, 4'b0010, 3'd2, 4'b0000, 2'd0, 1'b0, 1'b0, "single_arb");
        add(1'b0, 4'b0010, 3'd2, 4'b0010, 2'd1, 1'b0, 1'b1, "single_g1");
        add(1'b0, 4'b0010, 3'd2, 4'b0010, 2'd1, 1'b1, 1'b1, "single_last");
        add(1'b0, 4'b0000, 3'd2, 4'b0000, 2'd1, 1'b0, 1'b1, "single_release");
        add(1'b0, 4'b0000, 3'd2, 4'b0000, 2'd1, 1'b0, 1'b0, "single_idle");
        // Contention from reset: req[1] then req[3], burst of 3.
        add(1'b1, 4'b0000, 3'd0, 4'b0000, 2'd1, 1'b0, 1'b0, "cont_reset");
        add(1'b0, 4'b1010, 3'd3, 4'b0000, 2'd0, 1'b0, 1'b0, "cont_arb");
        add(1'b0, 4'b1010, 3'd3, 4'b0010, 2'd1, 1'b0, 1'b1, "cont_r1_g1");
        add(1'b0, 4'b1010, 3'd3, 4'b0010, 2'd1, 1'b0, 1'b1, "cont_r1_g2");
        add(1'b0, 4'b1010, 3'd3, 4'b0010, 2'd1, 1'b1, 1'b1, "cont_r1_last");
        add(1'b0, 4'b1000, 3'd3, 4'b0000, 2'd1, 1'b0, 1'b1, "cont_r1_release");
        add(1'b0, 4'b1000, 3'd3, 4'b1000, 2'd3, 1'b0, 1'b1, "cont_r3_g1");
        add(1'b0, 4'b1000, 3'd3, 4'b1000, 2'd3, 1'b0, 1'b1, "cont_r3_g2");
        add(1'b0, 4'b1000, 3'd3, 4'b1000, 2'd3, 1'b1, 1'b1, "cont_r3_last");
        add(1'b0, 4'b0000, 3'd3, 4'b0000, 2'd3, 1'b0, 1'b1, "cont_r3_release");
        add(1'b0, 4'b0000, 3'd3, 4'b0000, 2'd3, 1'b0, 1'b0, "cont_idle");
        // num_grants == 0 acts as one cycle.
        add(1'b0, 4'b0100, 3'd0, 4'b0000, 2'd3, 1'b0, 1'b0, "ng0_arb");
        add(1'b0, 4'b0100, 3'd0, 4'b0100, 2'd2, 1'b1, 1'b1, "ng0_last");
        add(1'b0, 4'b0000, 3'd0, 4'b0000, 2'd2, 1'b0, 1'b1, "ng0_release");
        add(1'b0, 4'b0000, 3'd0, 4'b0000, 2'd2, 1'b0, 1'b0, "ng0_idle");
        // Maximum burst of 7; pointer is at 3, so req[0] is found by wrap-around.
        add(1'b0, 4'b0001, 3'd7, 4'b0000, 2'd2, 1'b0, 1'b0, "ng7_arb");
        for (int i = 0; i < 6; i++) begin
            add(1'b0, 4'b0001, 3'd7, 4'b0001, 2'd0, 1'b0, 1'b1, "ng7_mid");
        end
        add(1'b0, 4'b0001, 3'd7, 4'b0001, 2'd0, 1'b1, 1'b1, "ng7_last");
        add(1'b0, 4'b0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b1, "ng7_release");
        add(1'b0, 4'b0000, 3'd0, 4'b0000, 2'd0, 1'b0, 1'b0, "ng7_idle");
        // Abort: req[2] drops after one of four grant cycles; next search starts at 3.
        add(1'b0, 4'b0100, 3'd4, 4'b0000, 2'd0, 1'b0, 1'b0, "abort_arb");
        add(1'b0, 4'b0100, 3'd4, 4'b0100, 2'd2, 1'b0, 1'b1, "abort_g1");
        add(1'b0, 4'b0000, 3'd4, 4'b0100, 2'd2, 1'b0, 1'b1, "abort_drop");
        add(1'b0, 4'b1001, 3'd1, 4'b0000, 2'd2, 1'b0, 1'b0, "abort_idle");
        add(1'b0, 4'b1001, 3'd1, 4'b1000, 2'd3, 1'b1, 1'b1, "abort_next_r3");
        add(1'b0, 4'b0001, 3'd1, 4'b0000, 2'd3, 1'b0, 1'b1, "abort_r3_release");
        add(1'b0, 4'b0001, 3'd1, 4'b0001, 2'd0, 1'b1, 1'b1, "abort_r0_last");
        add(1'b0, 4'b0000, 3'd1, 4'b0000, 2'd0, 1'b0, 1'b1, "abort_r0_release");
        add(1'b0, 4'b0000, 3'd1, 4'b0000, 2'd0, 1'b0, 1'b0, "abort_done");
        // Reset in the second grant cycle, then req[0] must win from pointer 0.
        add(1'b0, 4'b1000, 3'd4, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_arb");
        add(1'b0, 4'b1000, 3'd4, 4'b1000, 2'd3, 1'b0, 1'b1, "rst_g1");
        add(1'b1, 4'b1000, 3'd4, 4'b1000, 2'd3, 1'b0, 1'b1, "rst_g2_assert");
        add(1'b0, 4'b1001, 3'd2, 4'b0000, 2'd0, 1'b0, 1'b0, "rst_cleared");
        add(1'b0, 4'b1001, 3'd2, 4'b0001, 2'd0, 1'b0, 1'b1, "rst_r0_g1");
        add(1'b0, 4'b1001, 3'd2, 4'b0001, 2'd0, 1'b1, 1'b1, "rst_r0_last");
        add(1'b0, 4'b1000, 3'd2, 4'b0000, 2'd0, 1'b0, 1'b1, "rst_r0_release");
        add(1'b0, 4'b1000, 3'd2, 4'b1000, 2'd3, 1'b0, 1'b1, "rst_r3_g1");
        add(1'b0, 4'b1000, 3'd2, 4'b1000, 2'd3, 1'b1, 1'b1, "rst_r3_last");
        add(1'b0, 4'b0000, 3'd2, 4'b0000, 2'd3, 1'b0, 1'b1, "rst_r3_release");
        add(1'b0, 4'b0000, 3'd2, 4'b0000, 2'd3, 1'b0, 1'b0, "rst_idle");

        reset      = 1'b1;
        req        = 4'b0000;
        num_grants = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].req, vecs[i].ng, vecs[i].gnt, vecs[i].id, vecs[i].last,
                vecs[i].busy, vecs[i].name);
        end

        // Fairness: all four requesting, owner re-raises after its release cycle.
        cyc(1'b0, 4'b1111, 3'd1, 4'b0000, 2'd3, 1'b0, 1'b0, "rr_arb");
        for (int k = 0; k < 5; k++) begin
            o       = 2'(k % 4);
            oh      = 4'b0001 << o;
            rel_req = (k == 4) ? 4'b0000 : (4'b1111 & ~oh);
            cyc(1'b0, 4'b1111, 3'd1, oh, o, 1'b1, 1'b1, "rr_grant");
            cyc(1'b0, rel_req, 3'd1, 4'b0000, o, 1'b0, 1'b1, "rr_release");
        end
        cyc(1'b0, 4'b0000, 3'd1, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_idle");

        // Owner holds req after last: stuck in RELEASE, req[1] waits until req[2] drops.
        cyc(1'b0, 4'b0100, 3'd1, 4'b0000, 2'd0, 1'b0, 1'b0, "hold_arb");
        cyc(1'b0, 4'b0110, 3'd1, 4'b0100, 2'd2, 1'b1, 1'b1, "hold_last");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 4'b0110, 3'd1, 4'b0000, 2'd2, 1'b0, 1'b1, "hold_stuck");
        end
        cyc(1'b0, 4'b0010, 3'd1, 4'b0000, 2'd2, 1'b0, 1'b1, "hold_drop");
        cyc(1'b0, 4'b0010, 3'd1, 4'b0010, 2'd1, 1'b1, 1'b1, "hold_r1_last");
        cyc(1'b0, 4'b0000, 3'd1, 4'b0000, 2'd1, 1'b0, 1'b1, "hold_r1_release");
        cyc(1'b0, 4'b0000, 3'd1, 4'b0000, 2'd1, 1'b0, 1'b0, "hold_idle");

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_grant_arbiter.md
Name: burst_grant_arbiter

Overview:
- Shares one burst-grant resource between NUM_REQ requesters.
- Each winning requester receives num_grants consecutive gnt cycles. last marks the final grant cycle, and the requester then drops req.
- Round-robin fair. Sits between the requester-side req registers and the granted resource.
- Per-requester contract: req rises, gnt follows one cycle later for N cycles, req stays high until last, then falls.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
CNT_W, 3, width of num_grants and the internal burst counter
ID_W, $clog2(NUM_REQ), width of gnt_id (derived, not overridden)

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high; sampled only on posedge clk
req  in  NUM_REQ  level request per requester; held high from assertion until the cycle after its last
num_grants  in  CNT_W  burst length; sampled on the cycle a grant is awarded
gnt  out  NUM_REQ  one-hot grant, registered; at most one bit high
gnt_id  out  ID_W  index of current/most recent owner, registered
last  out  1  high only on the final gnt cycle of a completed burst
busy  out  1  high in GRANT and RELEASE states

Behaviour:
- Reset (synchronous): gnt=0, last=0, busy=0, gnt_id=0, state=IDLE, rr_ptr=0 (req[0] highest priority), count=0. A reset mid-burst drops gnt on the next edge with no last.
- States: IDLE, GRANT, RELEASE.
- IDLE: if any req bit is set at edge t:
  - winner = first set bit searching from rr_ptr upward, with wrap-around;
  - count <= eff_len-1, where eff_len = (num_grants==0) ? 1 : num_grants;
  - gnt[winner]=1 and gnt_id=winner from cycle t+1;
  - go to GRANT.
- GRANT: gnt held on the owner bit.
  - last = (count==0) and req[owner]==1, combinational from registered state; count decrements each cycle.
  - count==0 -> RELEASE; gnt drops at the next edge.
  - Latency: req high at edge t gives gnt high for cycles t+1..t+N, with last in cycle t+N.
- Abort: req[owner] low during GRANT.
  - gnt deasserts at the next edge, last is not asserted for that cycle.
  - state -> IDLE; rr_ptr <= owner+1.
- RELEASE: gnt=0; waits for req[owner]==0.
  - On that edge: rr_ptr <= owner+1 (mod NUM_REQ).
  - If another req bit is high, arbitrate immediately (owner excluded) using the new pointer; gnt starts the next cycle.
  - Otherwise go to IDLE.
- Owner req still high in RELEASE after last is a protocol violation: the arbiter stays in RELEASE. No grant is reissued and no other requester is served, so there is no starvation escape by design; verification flags it.
- Simultaneous requests: exactly one winner per the rr_ptr rule; losers keep req high and are served in rotation.
- Requests arriving during GRANT/RELEASE are not registered separately; only the level of req at arbitration time matters.
- Width rules:
  - count is CNT_W bits and never underflows (decrement only when count>0).
  - Maximum burst is 2^CNT_W-1 cycles; num_grants==0 behaves as 1.
- Invariants:
  - $onehot0(gnt).
  - last implies gnt!=0.
  - gnt_id is stable while busy.

Decomposition:
- Package burst_arb_pkg:
  - state enum (IDLE, GRANT, RELEASE);
  - function rr_pick(req, ptr) returning the index and a valid flag.
- One sub-module: rr_priority_picker. Combinational rotate / find-first / unrotate, parameterised by NUM_REQ. This keeps the FSM/counter in the top module.

Test Plan:
- Single requester, num_grants=2: req[1] rises at edge 5 -> gnt=4'b0010 in cycles 6-7, last in cycle 7; req drops at 8 -> busy=0 at 9.
- Contention: req=4'b1010 at edge 3 from reset, num_grants=3 -> req[1] gnt cycles 4-6, last at 6. req[1] drops at 7 -> gnt[3] in cycles 8-10.
- Round-robin fairness: all four req held high, re-raised after each last -> grant order 0,1,2,3,0; no index served twice before the others.
- num_grants=0 -> exactly one gnt cycle with last high; num_grants=7 -> seven gnt cycles, last on the seventh only.
- Abort: req[2] drops after 1 of 4 grant cycles -> gnt=0 the next cycle, last never high; next arbitration starts from index 3.
- Reset mid-burst: reset asserted in the 2nd gnt cycle -> all outputs 0 the next cycle, rr_ptr=0. After reset, req=4'b1001 -> req[0] wins.
